// File: rtl/iq_pkg.sv
// Shared types and helpers for the multi-wide instruction queue.
package iq_pkg;

    localparam int unsigned IQ_WIDTH = 32;
    localparam int unsigned IQ_PC_W  = 32;

    // One queued instruction with its fetch PC.
    typedef struct packed {
        logic [IQ_WIDTH-1:0] instr;
        logic [IQ_PC_W-1:0]  pc;
    } iq_entry_t;

    // Pointer advance modulo the queue depth; the caller truncates to pointer width.
    function automatic int unsigned ptr_add(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned depth);
        return (base + off) % depth;
    endfunction

    // Number of set bits among the lowest n bits of v.
    function automatic int unsigned prefix_popcount(input logic [31:0] v,
                                                    input int unsigned n);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((i < n) && v[i]) begin
                c = c + 1;
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    // True when the set bits of v form a contiguous run starting at bit 0.
    function automatic logic is_prefix(input logic [31:0] v);
        return (v & (v + 32'd1)) == 32'd0;
    endfunction

endpackage

// File: rtl/instr_queue_nway_chk.sv
// Protocol and invariant checks for instr_queue_nway.
module instr_queue_nway_chk
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ENQ_WIDTH = 2,
    parameter int unsigned DEQ_WIDTH = 2
) (
    input logic                           clk,
    input logic                           rst,
    input logic [ENQ_WIDTH-1:0]           enq_valid,
    input logic [$clog2(DEQ_WIDTH+1)-1:0] deq_take,
    input logic [$clog2(DEPTH+1)-1:0]     count
);

    if (!(((DEPTH & (DEPTH - 1)) == 0) && (DEPTH >= ENQ_WIDTH) && (DEPTH >= DEQ_WIDTH))) begin : g_bad_params
        $error("instr_queue_nway: DEPTH must be a power of 2 and at least max(ENQ_WIDTH, DEQ_WIDTH)");
    end

    a_enq_prefix: assert property (@(posedge clk) disable iff (rst)
        is_prefix(32'(enq_valid)))
        else $error("enq_valid is not a contiguous prefix from slot 0");

    a_take_overrun: assert property (@(posedge clk) disable iff (rst)
        32'(deq_take) <= ((32'(count) < DEQ_WIDTH) ? 32'(count) : DEQ_WIDTH))
        else $error("deq_take exceeds the number of valid dequeue slots");

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        32'(count) <= DEPTH)
        else $error("occupancy exceeds DEPTH");

endmodule

// File: rtl/instr_queue_nway.sv
// Multi-wide circular instruction queue between fetch and decode/rename.
// Up to ENQ_WIDTH entries in and DEQ_WIDTH entries out per cycle, with flush.
module instr_queue_nway
    import iq_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ENQ_WIDTH = 2,
    parameter int unsigned DEQ_WIDTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [ENQ_WIDTH-1:0]                enq_valid,
    input  logic [ENQ_WIDTH-1:0][WIDTH-1:0]     enq_instr,
    input  logic [ENQ_WIDTH-1:0][31:0]          enq_pc,
    output logic                                enq_ready,
    output logic [DEQ_WIDTH-1:0]                deq_valid,
    output logic [DEQ_WIDTH-1:0][WIDTH-1:0]     deq_instr,
    output logic [DEQ_WIDTH-1:0][31:0]          deq_pc,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0]      deq_take,
    output logic [$clog2(DEPTH+1)-1:0]          count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_instr_q [DEPTH];
    logic [WIDTH-1:0] mem_instr_d [DEPTH];
    logic [31:0]      mem_pc_q    [DEPTH];
    logic [31:0]      mem_pc_d    [DEPTH];

    logic             enq_fire;
    logic [CNT_W-1:0] enq_num;
    logic [CNT_W-1:0] take_num;
    logic [CNT_W-1:0] avail;

    // Room check uses registered occupancy only, so a same-cycle take never raises it.
    always_comb begin
        enq_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(ENQ_WIDTH);
    end

    // Next pointers, occupancy and storage writes; flush discards the in-flight transfer.
    always_comb begin
        avail    = (count_q > CNT_W'(DEQ_WIDTH)) ? CNT_W'(DEQ_WIDTH) : count_q;
        take_num = (CNT_W'(deq_take) > avail) ? avail : CNT_W'(deq_take);
        enq_fire = enq_ready && !flush;
        if (enq_fire) begin
            enq_num = CNT_W'(prefix_popcount(32'(enq_valid), ENQ_WIDTH));
        end else begin
            enq_num = {CNT_W{1'b0}};
        end

        mem_instr_d = mem_instr_q;
        mem_pc_d    = mem_pc_q;
        for (int unsigned k = 0; k < ENQ_WIDTH; k++) begin
            if (enq_fire && enq_valid[k]) begin
                mem_instr_d[PTR_W'(ptr_add(32'(tail_q), k, DEPTH))] = enq_instr[k];
                mem_pc_d[PTR_W'(ptr_add(32'(tail_q), k, DEPTH))]    = enq_pc[k];
            end else begin
                mem_instr_d = mem_instr_d;
            end
        end

        if (flush) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            head_d  = PTR_W'(ptr_add(32'(head_q), 32'(take_num), DEPTH));
            tail_d  = PTR_W'(ptr_add(32'(tail_q), 32'(enq_num), DEPTH));
            count_d = count_q + enq_num - take_num;
        end
    end

    // Pointer and occupancy registers; reset outranks flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are qualified by occupancy so it needs no reset.
    always_ff @(posedge clk) begin
        mem_instr_q <= mem_instr_d;
        mem_pc_q    <= mem_pc_d;
    end

    // Present the oldest entries, zeroing slots that hold nothing.
    always_comb begin
        count = count_q;
        for (int unsigned i = 0; i < DEQ_WIDTH; i++) begin
            deq_valid[i] = count_q > CNT_W'(i);
            if (deq_valid[i]) begin
                deq_instr[i] = mem_instr_q[PTR_W'(ptr_add(32'(head_q), i, DEPTH))];
                deq_pc[i]    = mem_pc_q[PTR_W'(ptr_add(32'(head_q), i, DEPTH))];
            end else begin
                deq_instr[i] = {WIDTH{1'b0}};
                deq_pc[i]    = 32'd0;
            end
        end
    end

    instr_queue_nway_chk #(
        .DEPTH     (DEPTH),
        .ENQ_WIDTH (ENQ_WIDTH),
        .DEQ_WIDTH (DEQ_WIDTH)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .enq_valid (enq_valid),
        .deq_take  (deq_take),
        .count     (count_q)
    );

endmodule
